// File: rtl/proj_pkg.sv
// Shared types and sizing for the FM shingle pipeline.
package proj_pkg;

  localparam int FM_BUFFER_SIZE               = 16;
  localparam int FM_EXTENDER_BYTES_READ_COUNT = 4;
  localparam int SHINGLE_W                    = FM_EXTENDER_BYTES_READ_COUNT * 8;
  localparam int DROP_CNT_W                   = 16;

  typedef enum logic [1:0] {
    EXT_IDLE,
    EXT_FILL,
    EXT_STREAM
  } ext_state_e;

endpackage

// File: rtl/proj_fm_byte_buffer.sv
// Circular FM byte buffer: one write port, RD_PORTS combinational read ports
// where port j (1-based) reads the entry j positions behind the write index.
module proj_fm_byte_buffer #(
  parameter int SIZE     = 16,
  parameter int RD_PORTS = 3,
  parameter int BYTE_W   = 8,
  parameter int IW       = SIZE
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [IW-1:0]              wr_index,
  input  logic [BYTE_W-1:0]          wr_data,
  output logic [RD_PORTS*BYTE_W-1:0] rd_data
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [BYTE_W-1:0] mem [SIZE];

  // (idx - j) mod SIZE, computed one bit wider so the subtraction never underflows
  function automatic logic [AW-1:0] rd_addr(input logic [IW-1:0] idx, input int j);
    logic [IW:0] a;
    a = {1'b0, idx} + (IW+1)'(SIZE - j);
    if (a >= (IW+1)'(SIZE)) a = a - (IW+1)'(SIZE);
    return AW'(a);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[AW'(wr_index)] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int j = 1; j <= RD_PORTS; j++) begin
      rd_data[(j-1)*BYTE_W +: BYTE_W] = mem[rd_addr(wr_index, j)];
    end
  end

endmodule

// File: rtl/proj_fm_shingle_extender.sv
// Builds K-byte shingles from the FM byte stream and hands them to MinHash.
// Optional drop counter is built when PROJ_EXT_DROP_CNT_EN is defined.
//
// state      | meaning
// EXT_IDLE   | no contiguous bytes held
// EXT_FILL   | 1..K-1 contiguous bytes held, no shingle yet
// EXT_STREAM | K contiguous bytes held, every valid byte emits a shingle
module proj_fm_shingle_extender #(
  parameter int FM_BUFFER_SIZE       = proj_pkg::FM_BUFFER_SIZE,
  parameter int READ_ADDRESSES_COUNT = proj_pkg::FM_EXTENDER_BYTES_READ_COUNT,
  parameter int BYTE_W               = 8
) (
  input  logic                                   in_clk,
  input  logic                                   in_rst_n,
  input  logic [FM_BUFFER_SIZE-1:0]              in_wr_index,
  input  logic [BYTE_W-1:0]                      in_byte,
  input  logic                                   in_byte_valid,
  input  logic                                   in_flush,
  input  logic                                   in_clr_ovf,
  output logic [READ_ADDRESSES_COUNT*BYTE_W-1:0] out_shingle,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_overflow,
  output logic [proj_pkg::DROP_CNT_W-1:0]        out_drop_cnt
);

  import proj_pkg::*;

  localparam int K  = READ_ADDRESSES_COUNT;
  localparam int FW = $clog2(K + 1);

  ext_state_e                  state_q;
  logic [FW-1:0]               fill_q;
  logic [FW-1:0]               fill_inc;
  logic [(K-1)*BYTE_W-1:0]     rd_data;
  logic [K*BYTE_W-1:0]         shingle_next;
  logic                        wr_en;
  logic                        emit;
  logic                        drop;

  assign wr_en    = in_byte_valid & ~in_flush;
  assign fill_inc = fill_q + FW'(1);
  assign emit     = wr_en && ((state_q == EXT_FILL && fill_inc == FW'(K)) ||
                              state_q == EXT_STREAM);
  assign drop     = emit & out_valid & ~out_ready;

  // newest byte bypasses the buffer; older bytes come from read ports j=K-1..1
  assign shingle_next = {rd_data, in_byte};

  proj_fm_byte_buffer #(
    .SIZE     (FM_BUFFER_SIZE),
    .RD_PORTS (K - 1),
    .BYTE_W   (BYTE_W),
    .IW       (FM_BUFFER_SIZE)
  ) u_buf (
    .clk      (in_clk),
    .wr_en    (wr_en),
    .wr_index (in_wr_index),
    .wr_data  (in_byte),
    .rd_data  (rd_data)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q      <= EXT_IDLE;
      fill_q       <= '0;
      out_shingle  <= '0;
      out_valid    <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (!wr_en) begin
        state_q <= EXT_IDLE;
        fill_q  <= '0;
      end else begin
        case (state_q)
          EXT_IDLE: begin
            state_q <= EXT_FILL;
            fill_q  <= FW'(1);
          end
          EXT_FILL: begin
            fill_q <= fill_inc;
            if (fill_inc == FW'(K)) state_q <= EXT_STREAM;
          end
          EXT_STREAM: fill_q <= FW'(K);
          default: begin
            state_q <= EXT_IDLE;
            fill_q  <= '0;
          end
        endcase
      end

      if (emit) begin
        out_shingle <= shingle_next;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop)            out_overflow <= 1'b1;
      else if (in_clr_ovf) out_overflow <= 1'b0;
    end
  end

`ifdef PROJ_EXT_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      drop_cnt_q <= '0;
    end else if (in_clr_ovf) begin
      drop_cnt_q <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && drop_cnt_q != '1) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign out_drop_cnt = drop_cnt_q;
`else
  assign out_drop_cnt = '0;
`endif

endmodule

// File: doc/proj_fm_shingle_extender.md
Name: proj_fm_shingle_extender

Overview:
- Downstream consumer of the FM index counter. Each cycle it takes the counter's write index and an incoming byte, and stores the byte in a circular FM byte buffer.
- Once READ_ADDRESSES_COUNT contiguous bytes of an unbroken stream are held, it emits one shingle per valid byte: the last K bytes, with circular read addressing.
- The shingle goes to the MinHash hashing stage over a valid/ready handshake.

Parameters:
- FM_BUFFER_SIZE, proj_pkg::FM_BUFFER_SIZE, buffer depth in bytes; index width is FM_BUFFER_SIZE bits.
- READ_ADDRESSES_COUNT, proj_pkg::FM_EXTENDER_BYTES_READ_COUNT, shingle length K; requires 2 <= K <= FM_BUFFER_SIZE.
- BYTE_W, 8, data width per buffer entry.

Ports:
- in_clk, input, 1, clock.
- in_rst_n, input, 1, asynchronous active-low reset.
- in_wr_index, input, FM_BUFFER_SIZE, write index from the counter; values 0..FM_BUFFER_SIZE-1, wraps to 0.
- in_byte, input, BYTE_W, stream byte.
- in_byte_valid, input, 1, in_byte valid this cycle.
- in_flush, input, 1, document boundary; discards the partial window.
- in_clr_ovf, input, 1, clears the sticky overflow flag.
- out_shingle, output, K*BYTE_W, K bytes; oldest in MSBs, newest in LSBs.
- out_valid, output, 1, shingle valid.
- out_ready, input, 1, downstream accepts.
- out_overflow, output, 1, sticky: a shingle was overwritten before it was accepted.
- out_drop_cnt, output, 16, dropped shingle count (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert use):
  - buffer contents are don't-care; fill count 0; state IDLE;
  - out_valid=0, out_shingle=0, out_overflow=0, out_drop_cnt=0.
- Write: when in_byte_valid=1, buf[in_wr_index] <= in_byte. Only in_wr_index is used for addressing; the block never advances its own write pointer.
- Read window: read addresses are (in_wr_index - j) mod FM_BUFFER_SIZE, for j = K-1 down to 1.
  - Wrap example with size 16 and idx=1: addresses 14, 15, 0.
  - The newest byte is bypassed from in_byte, not read back from the buffer.
- FSM (state in proj_pkg):
  - IDLE: valid -> FILL, fill=1.
  - FILL: valid -> fill+1; if fill+1==K -> STREAM and emit.
  - STREAM: valid -> emit.
  - In any state, in_byte_valid=0 (a stream gap) -> IDLE, fill=0. Gaps break contiguity, because the counter advances every cycle.
- Emit: out_shingle and out_valid are registered 1 cycle after the byte that completes the window. Latency is 1.
- Handshake:
  - out_valid stays asserted until the cycle where out_valid & out_ready; it then drops unless a new emit happens in the same cycle.
  - Emit with out_valid=1 and out_ready=0: the new shingle overwrites the held one, out_overflow <= 1, and the drop count increments.
  - Emit in the same cycle as acceptance: out_valid stays 1 with the new data, no drop.
- in_flush (priority over valid):
  - state -> IDLE, fill=0; the byte in a flush cycle is neither written nor counted;
  - a pending out_valid is preserved.
- in_clr_ovf clears out_overflow; a simultaneous new overflow wins (flag stays 1).
- Fill counter width is clog2(K+1); it saturates at K in STREAM.

Optional Feature:
- Macro PROJ_EXT_DROP_CNT_EN.
- Defined: out_drop_cnt is a 16-bit saturating counter (holds at 0xFFFF) of overwritten shingles, cleared together with out_overflow by in_clr_ovf. A simultaneous drop leaves it at 1.
- Undefined: no counter is built; out_drop_cnt is tied to 0; out_overflow behaviour is unchanged.

Decomposition:
- proj_pkg gains:
  - typedef enum logic [1:0] {EXT_IDLE, EXT_FILL, EXT_STREAM} ext_state_e;
  - localparam SHINGLE_W = FM_EXTENDER_BYTES_READ_COUNT*8;
  - localparam DROP_CNT_W = 16.
- One sub-module, proj_fm_byte_buffer: register array of FM_BUFFER_SIZE x BYTE_W, one write port, K-1 combinational circular read ports. FSM, bypass and handshake stay in the top.

Test Plan (FM_BUFFER_SIZE=16, K=4, out_ready=1 unless stated):
- Stream bytes 0x01..0x06 at idx 0..5 with valid every cycle -> first out_valid one cycle after idx 3 with shingle 0x01020304, then 0x02030405, then 0x03040506.
- Bytes 0xA0..0xA5 at idx 13,14,15,0,1,2 (wrap) -> shingle at idx 0 is 0xA0A1A2A3; at idx 2 it is 0xA2A3A4A5.
- Valid gap after 3 bytes, then 4 more -> no shingle until 4 contiguous bytes after the gap; the first shingle contains post-gap bytes only.
- out_ready=0 for 3 emits -> out_shingle shows the latest window, out_overflow=1, out_drop_cnt=2 (EN) or 0 (not EN). Pulse in_clr_ovf -> both clear.
- in_flush mid-STREAM with a pending unaccepted shingle -> pending shingle still delivered; the next shingle needs 4 fresh bytes.
- Assert in_rst_n=0 asynchronously mid-STREAM -> out_valid=0 and out_overflow=0 immediately; after release, 3 bytes produce no output.
